alu_bist_engine: RTL and testbench

//  Built-in self-test sequencer for the single-cycle datapath ALU. It walks a fixed table of
//  {data1, data2, ALUOp, shamt, expected result, expected zero} vectors, drives the ALU operand

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_bist_rom.sv | 34 +++
 rtl/alu_bist_engine.sv | 139 +++++++++++++
 tb/tb_alu_bist_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode encodings, BIST FSM states and test vector record
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SUBU = 4'b1010;

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} bist_state_t;

    localparam int VEC_W = 106;

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        logic [3:0]  op;
        logic [4:0]  shamt;
        logic [31:0] exp_result;
        logic        exp_zero;
    } bist_vec_t;

endpackage

// File: rtl/alu_bist_rom.sv
// rtl/alu_bist_rom.sv - combinational BIST vector table, index to vector record
module alu_bist_rom
    import alu_pkg::*;
#(
    parameter int NUM_VEC = 12
) (
    input  logic [7:0] idx,
    output bist_vec_t  vec
);

    // Shifts act on data2 by shamt; every vector except the two equal-operand
    // subtractions produces a non-zero result so a stuck zero flag shows up only there.
    always_comb begin
        vec = '0;
        if (int'({24'd0, idx}) < NUM_VEC) begin
            case (idx)
                8'd0:  vec = '{32'h81555FCD, 32'h0003FFF0, OP_ADD,  5'd0,  32'h81595FBD, 1'b0};
                8'd1:  vec = '{32'hF0F0F0F0, 32'h3C3C3C3C, OP_AND,  5'd0,  32'h30303030, 1'b0};
                8'd2:  vec = '{32'h0F0F0000, 32'h00F000FF, OP_NOR,  5'd0,  32'hF000FF00, 1'b0};
                8'd3:  vec = '{32'h12340000, 32'h00005678, OP_OR,   5'd0,  32'h12345678, 1'b0};
                8'd4:  vec = '{32'h00000000, 32'h000000A5, OP_SLL,  5'd4,  32'h00000A50, 1'b0};
                8'd5:  vec = '{32'h00000000, 32'h80000000, OP_SRL,  5'd31, 32'h00000001, 1'b0};
                8'd6:  vec = '{32'hFFFFFFFF, 32'h00000001, OP_SLT,  5'd0,  32'h00000001, 1'b0};
                8'd7:  vec = '{32'h00000001, 32'hFFFFFFFF, OP_SLTU, 5'd0,  32'h00000001, 1'b0};
                8'd8:  vec = '{32'h00000010, 32'h00000003, OP_SUB,  5'd0,  32'h0000000D, 1'b0};
                8'd9:  vec = '{32'h00000000, 32'h00000001, OP_SUBU, 5'd0,  32'hFFFFFFFF, 1'b0};
                8'd10: vec = '{32'h12345678, 32'h12345678, OP_SUB,  5'd0,  32'h00000000, 1'b1};
                8'd11: vec = '{32'hA5A5A5A5, 32'hA5A5A5A5, OP_SUBU, 5'd0,  32'h00000000, 1'b1};
                default: vec = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_bist_engine.sv
// rtl/alu_bist_engine.sv - ALU self-test sequencer: drives vectors, checks results, reports
module alu_bist_engine
    import alu_pkg::*;
#(
    parameter int NUM_VEC       = 12,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [31:0]      alu_data1,
    output logic [31:0]      alu_data2,
    output logic [3:0]       alu_op,
    output logic [4:0]       alu_shamt,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic [7:0]       first_fail_idx
);

    localparam logic [7:0]       LAST_IDX      = 8'(NUM_VEC - 1);
    localparam int               SETTLE_LAST_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [3:0]       SETTLE_LAST   = 4'(SETTLE_LAST_I);
    localparam logic [CNT_W-1:0] ERR_MAX       = '1;

    bist_state_t state;
    logic [7:0]  idx;
    logic [7:0]  rom_idx;
    logic [3:0]  settle_cnt;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        mismatch;
    bist_vec_t   vec;

    // The ROM is addressed with the index being loaded on DRIVE entry, so the
    // expected response of the vector in flight is captured alongside the operands.
    always_comb begin
        rom_idx = 8'd0;
        if (state == CHECK) begin
            rom_idx = idx + 8'd1;
        end
    end

    alu_bist_rom #(.NUM_VEC(NUM_VEC)) u_rom (
        .idx (rom_idx),
        .vec (vec)
    );

    assign mismatch = ({alu_result, alu_zero} != {exp_result, exp_zero});

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= 8'd0;
            settle_cnt     <= 4'd0;
            exp_result     <= 32'd0;
            exp_zero       <= 1'b0;
            alu_data1      <= 32'd0;
            alu_data2      <= 32'd0;
            alu_op         <= OP_NOP;
            alu_shamt      <= 5'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= DRIVE;
                        idx            <= 8'd0;
                        err_count      <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_idx <= 8'd0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        alu_data1      <= vec.data1;
                        alu_data2      <= vec.data2;
                        alu_op         <= vec.op;
                        alu_shamt      <= vec.shamt;
                        exp_result     <= vec.exp_result;
                        exp_zero       <= vec.exp_zero;
                    end
                end
                DRIVE: begin
                    settle_cnt <= 4'd0;
                    state      <= (SETTLE_CYCLES == 0) ? CHECK : WAIT;
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!fail_valid) begin
                            fail_valid     <= 1'b1;
                            first_fail_idx <= idx;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_count == '0) && !mismatch;
                        alu_data1 <= 32'd0;
                        alu_data2 <= 32'd0;
                        alu_op    <= OP_NOP;
                        alu_shamt <= 5'd0;
                    end else begin
                        state      <= DRIVE;
                        idx        <= idx + 8'd1;
                        alu_data1  <= vec.data1;
                        alu_data2  <= vec.data2;
                        alu_op     <= vec.op;
                        alu_shamt  <= vec.shamt;
                        exp_result <= vec.exp_result;
                        exp_zero   <= vec.exp_zero;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_engine.sv
// tb/tb_alu_bist_engine.sv - randomized self-checking bench with behavioural ALU model
module tb_alu_bist_engine;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;

    logic [31:0] alu_data1_a, alu_data2_a, alu_result_a;
    logic [3:0]  alu_op_a;
    logic [4:0]  alu_shamt_a;
    logic        alu_zero_a, busy_a, done_a, pass_a, fail_valid_a;
    logic [7:0]  err_count_a, first_fail_idx_a;

    logic [31:0] alu_data1_b, alu_data2_b, alu_result_b;
    logic [3:0]  alu_op_b;
    logic [4:0]  alu_shamt_b;
    logic        alu_zero_b, busy_b, done_b, pass_b, fail_valid_b;
    logic [7:0]  err_count_b, first_fail_idx_b;

    int          mode_a = 0, mode_b = 0;
    logic [3:0]  cop_a = 4'd0, cop_b = 4'd0;
    logic [31:0] mask_a = 32'd0, mask_b = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] tv_d1 [12];
    logic [31:0] tv_d2 [12];
    logic [3:0]  tv_op [12];
    logic [4:0]  tv_sh [12];

    always #5 clk = ~clk;

    alu_bist_engine #(.NUM_VEC(12), .SETTLE_CYCLES(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .alu_data1(alu_data1_a), .alu_data2(alu_data2_a), .alu_op(alu_op_a), .alu_shamt(alu_shamt_a),
        .alu_result(alu_result_a), .alu_zero(alu_zero_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_count_a),
        .fail_valid(fail_valid_a), .first_fail_idx(first_fail_idx_a)
    );

    alu_bist_engine #(.NUM_VEC(12), .SETTLE_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .alu_data1(alu_data1_b), .alu_data2(alu_data2_b), .alu_op(alu_op_b), .alu_shamt(alu_shamt_b),
        .alu_result(alu_result_b), .alu_zero(alu_zero_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
        .fail_valid(fail_valid_b), .first_fail_idx(first_fail_idx_b)
    );

    function automatic logic [31:0] alu_golden(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a & b;
            4'd3:    return ~(a | b);
            4'd4:    return a | b;
            4'd5:    return b << sh;
            4'd6:    return b >> sh;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:    return (a < b) ? 32'd1 : 32'd0;
            4'd9:    return a - b;
            4'd10:   return a - b;
            default: return 32'd0;
        endcase
    endfunction

    // mode 0 golden, 1 flips mask bits of the result for opcode cop, 2 zero flag stuck low
    function automatic logic [32:0] alu_resp(input int mode, input logic [3:0] cop, input logic [31:0] mask,
                                             input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        r = alu_golden(op, a, b, sh);
        if (mode == 1 && op == cop) r = r ^ mask;
        if (mode == 2) return {1'b0, r};
        return {(r == 32'd0), r};
    endfunction

    always_comb {alu_zero_a, alu_result_a} = alu_resp(mode_a, cop_a, mask_a, alu_op_a, alu_data1_a, alu_data2_a, alu_shamt_a);
    always_comb {alu_zero_b, alu_result_b} = alu_resp(mode_b, cop_b, mask_b, alu_op_b, alu_data1_b, alu_data2_b, alu_shamt_b);

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic predict(input int mode, input logic [3:0] cop, input logic [31:0] mask,
                           output int errs, output int first);
        logic [32:0] g, f;
        errs  = 0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            g = alu_resp(0, cop, mask, tv_op[i], tv_d1[i], tv_d2[i], tv_sh[i]);
            f = alu_resp(mode, cop, mask, tv_op[i], tv_d1[i], tv_d2[i], tv_sh[i]);
            if (g != f) begin
                errs++;
                if (first < 0) first = i;
            end
        end
    endtask

    // Pulses start on dut_a, optionally re-pulses it at edges ign1/ign2, returns done edge and busy cycles.
    task automatic run_a(input int ign1, input int ign2, output int done_edge, output int busy_cnt);
        int n;
        done_edge = -1;
        busy_cnt  = 0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (n < 200) begin
            if (busy_a) busy_cnt++;
            if (n < 36) begin
                check_val("op_seq", alu_op_a, tv_op[n / 3]);
                check_val("data1_seq", alu_data1_a, tv_d1[n / 3]);
            end
            if (done_a) begin
                done_edge = n;
                break;
            end
            if (n == ign1 || n == ign2) start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            n++;
        end
        if (done_edge < 0) check_val("done_timeout", 0, 1);
    endtask

    task automatic check_result_a(input string tag, input int mode, input logic [3:0] cop,
                                  input logic [31:0] mask, input int de, input int bc);
        int errs, first;
        predict(mode, cop, mask, errs, first);
        check_val({tag, "_done_edge"}, de, 36);
        check_val({tag, "_busy_cycles"}, bc, 36);
        check_val({tag, "_err_count"}, err_count_a, errs);
        check_val({tag, "_fail_valid"}, fail_valid_a, errs > 0);
        check_val({tag, "_first_fail"}, first_fail_idx_a, (first < 0) ? 0 : first);
        check_val({tag, "_pass"}, pass_a, errs == 0);
        check_val({tag, "_op_idle"}, alu_op_a, 0);
    endtask

    initial begin
        int de, bc, n;
        tv_d1 = '{32'h81555FCD, 32'hF0F0F0F0, 32'h0F0F0000, 32'h12340000, 32'h00000000, 32'h00000000,
                  32'hFFFFFFFF, 32'h00000001, 32'h00000010, 32'h00000000, 32'h12345678, 32'hA5A5A5A5};
        tv_d2 = '{32'h0003FFF0, 32'h3C3C3C3C, 32'h00F000FF, 32'h00005678, 32'h000000A5, 32'h80000000,
                  32'h00000001, 32'hFFFFFFFF, 32'h00000003, 32'h00000001, 32'h12345678, 32'hA5A5A5A5};
        tv_op = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd9, 4'd10};
        tv_sh = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_outputs_a", {alu_data1_a, alu_op_a, alu_shamt_a, busy_a, done_a, pass_a, fail_valid_a},
                  0);
        check_val("rst_counters_a", {err_count_a, first_fail_idx_a, alu_data2_a}, 0);
        check_val("rst_outputs_b", {alu_data1_b, alu_op_b, busy_b, done_b, pass_b, err_count_b}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // golden run with starts during busy at cycles 5 and 20
        mode_a = 0;
        run_a(5, 20, de, bc);
        check_result_a("golden", 0, 4'd0, 32'd0, de, bc);
        repeat (3) @(posedge clk);
        #1;
        check_val("done_held", done_a, 1);

        // single bit corruption on SLL (vector 4)
        mode_a = 1; cop_a = 4'd5; mask_a = 32'd1;
        run_a(-1, -1, de, bc);
        check_result_a("sll_bit0", 1, 4'd5, 32'd1, de, bc);
        check_val("sll_first_is_4", first_fail_idx_a, 4);

        // zero flag stuck low
        mode_a = 2;
        run_a(-1, -1, de, bc);
        check_result_a("zero_low", 2, 4'd0, 32'd0, de, bc);
        check_val("zero_low_errs_2", err_count_a, 2);

        // random corruptions and random ignored start pulses
        for (int k = 0; k < 6; k++) begin
            mode_a = 1;
            cop_a  = 4'($urandom_range(1, 10));
            mask_a = 32'd1 << $urandom_range(0, 31);
            run_a(int'($urandom_range(1, 34)), int'($urandom_range(1, 34)), de, bc);
            check_result_a("random", 1, cop_a, mask_a, de, bc);
        end

        // reset mid-run
        mode_a = 1; cop_a = 4'd1; mask_a = 32'h80;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_outputs", {alu_data1_a, alu_op_a, alu_shamt_a, busy_a, done_a, pass_a, fail_valid_a}, 0);
        check_val("midrst_counters", {err_count_a, first_fail_idx_a, alu_data2_a}, 0);
        reset = 1'b0;
        mode_a = 0;
        @(posedge clk); #1;
        run_a(-1, -1, de, bc);
        check_result_a("after_rst", 0, 4'd0, 32'd0, de, bc);

        // zero settle cycles on dut_b
        mode_b = 2;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        check_val("b_v0_op_c0", alu_op_b, 4'd1);
        check_val("b_v0_d1", alu_data1_b, 32'h81555FCD);
        check_val("b_v0_d2", alu_data2_b, 32'h0003FFF0);
        check_val("b_v0_result", alu_result_b, 32'h81595FBD);
        @(posedge clk); #1;
        check_val("b_v0_op_c1", alu_op_b, 4'd1);
        @(posedge clk); #1;
        check_val("b_v1_op", alu_op_b, 4'd2);
        n = 2;
        while (!done_b && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("b_done_edge", n, 24);
        check_val("b_err_count", err_count_b, 2);
        check_val("b_first_fail", first_fail_idx_b, 10);

        // restart from DONE clears the previous result on the start edge
        mode_b = 0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        check_val("b_restart_clear", {err_count_b, fail_valid_b, first_fail_idx_b, done_b, pass_b}, 0);
        check_val("b_restart_busy", busy_b, 1);
        n = 0;
        while (!done_b && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("b_restart_done_edge", n, 24);
        check_val("b_restart_pass", {pass_b, err_count_b}, 9'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
